// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data SRAM port arbiter.
package mem_port_arbiter_pkg;

    // One in-flight read: whether the slot is live and who asked for it.
    typedef struct packed {
        logic valid;
        logic is_fetch;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Byte-enable pattern that marks a data request as a load.
    localparam logic [3:0] WE_LOAD = 4'b0000;

endpackage

// File: rtl/mem_tag_pipe.sv
// Owner tag delay line matching the SRAM read latency, with a fetch-kill input
// that squashes every in-flight fetch on a branch redirect.
module mem_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_fetch,
    input  logic kill_fetch,
    output logic out_vld,
    output logic out_fetch
);

    logic [TAG_W-1:0] tag_p [RAM_LAT];

    // Shift tags one stage per cycle; fetch tags lose their valid bit on a kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= tag_t'{valid: push_vld, is_fetch: push_fetch};
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_p[i] <= tag_t'{valid:    tag_p[i-1][1] & ~(kill_fetch & tag_p[i-1][0]),
                                   is_fetch: tag_p[i-1][0]};
            end
        end
    end

    // A fetch completing in the redirect cycle is stale as well, so mask it here.
    always_comb begin
        out_fetch = tag_p[RAM_LAT-1][0];
        out_vld   = tag_p[RAM_LAT-1][1] & ~(kill_fetch & tag_p[RAM_LAT-1][0]);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access, with data
// priority, a fetch anti-starvation counter and response routing by owner tag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 12,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic          stall_F,
    output logic          stall_M
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          ld_out;
    logic          tag_vld;
    logic          tag_fetch;
    logic          d_is_load;
    logic          d_can;
    logic          if_can;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    mem_tag_pipe #(
        .RAM_LAT (RAM_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_vld   (if_gnt | (d_gnt & d_is_load)),
        .push_fetch (if_gnt),
        .kill_fetch (if_flush),
        .out_vld    (tag_vld),
        .out_fetch  (tag_fetch)
    );

    // Arbitration, response routing and stalls; everything is held at 0 during reset.
    always_comb begin
        d_is_load = (d_we == WE_LOAD);
        if_rvalid = ~rst & tag_vld & tag_fetch;
        d_rvalid  = ~rst & tag_vld & ~tag_fetch;
        if_rdata  = if_rvalid ? ram_rdata : 32'h0;
        d_rdata   = d_rvalid ? ram_rdata : 32'h0;
        // A new data grant may overlap the cycle the previous load returns.
        d_can     = d_req & (~ld_out | d_rvalid);
        if_can    = if_req & ~if_flush;
        if_gnt    = ~rst & if_can & (~d_can | (starve_cnt == STARVE_LIM));
        d_gnt     = ~rst & d_can & ~if_gnt;
        stall_F   = ~rst & if_req & ~if_gnt;
        stall_M   = ~rst & ((d_req & ~d_gnt) | (ld_out & ~d_rvalid));
    end

    // SRAM command follows whichever requester won this cycle.
    always_comb begin
        ram_en    = if_gnt | d_gnt;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = 32'h0;
        if (d_gnt) begin
            ram_we    = d_we;
            ram_addr  = d_addr[AW+1:2];
            ram_wdata = d_wdata;
        end else if (if_gnt) begin
            ram_addr  = if_addr[AW+1:2];
        end
    end

    // Starvation counter and single-outstanding-load tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            ld_out     <= 1'b0;
        end else begin
            if (~if_req | if_flush | if_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (d_gnt & d_is_load) begin
                ld_out <= 1'b1;
            end else if (d_rvalid) begin
                ld_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 2) share one
// stimulus stream; a calendar-based reference model predicts every output.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        ram_en    [2];
    logic [3:0]  ram_we    [2];
    logic [11:0] ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic        stall_F   [2];
    logic        stall_M   [2];

    logic [31:0] ram_mem [2][4096];
    logic [31:0] ref_mem [2][4096];
    logic [31:0] rd_l1, rd_l2a, rd_l2b;

    logic        slot_v [2][8];
    logic        slot_f [2][8];
    logic [31:0] slot_d [2][8];
    int          starve [2];
    logic        ld_out [2];
    int          cyc;
    int          total;
    int          bad;

    mem_port_arbiter #(.AW(12), .RAM_LAT(1), .STARVE_MAX(SMAX)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .stall_F(stall_F[0]), .stall_M(stall_M[0])
    );

    mem_port_arbiter #(.AW(12), .RAM_LAT(2), .STARVE_MAX(SMAX)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .stall_F(stall_F[1]), .stall_M(stall_M[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input logic [11:0] w);
        return ({20'h0, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // SRAM models; read data is random filler whenever no read was issued.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                ram_mem[0][i] <= init_word(12'(i));
                ram_mem[1][i] <= init_word(12'(i));
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ram_en[k] && ram_we[k] != 4'h0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_we[k][b]) ram_mem[k][ram_addr[k]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
                    end
                end
            end
        end
        rd_l1  <= (ram_en[0] && ram_we[0] == 4'h0) ? ram_mem[0][ram_addr[0]] : $urandom;
        rd_l2a <= (ram_en[1] && ram_we[1] == 4'h0) ? ram_mem[1][ram_addr[1]] : $urandom;
        rd_l2b <= rd_l2a;
    end

    assign ram_rdata[0] = rd_l1;
    assign ram_rdata[1] = rd_l2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_or(input int k);
        return {20'h0, if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], ram_en[k], stall_F[k],
                stall_M[k], |ram_we[k], |ram_addr[k], |ram_wdata[k], |if_rdata[k], |d_rdata[k]};
    endfunction

    // Reference: responses sit in a calendar indexed by their due cycle.
    task automatic model_cycle(input int k);
        int L, s, t;
        logic resp, rfetch, d_ok, f_ok;
        logic e_ifg, e_dg, e_ifv, e_dv, e_stf, e_stm;
        logic [31:0] rdat, e_wd, e_ifd, e_dd;
        logic [3:0]  e_we;
        logic [11:0] e_addr, dw;
        logic [118:0] ev, ov;
        L = k + 1;
        s = cyc % 8;
        e_ifg = 0; e_dg = 0; e_ifv = 0; e_dv = 0; e_stf = 0; e_stm = 0;
        e_we = 0; e_addr = 0; e_wd = 0; e_ifd = 0; e_dd = 0;
        if (rst) begin
            for (int j = 0; j < 8; j++) slot_v[k][j] = 1'b0;
            starve[k] = 0;
            ld_out[k] = 1'b0;
        end else begin
            resp   = slot_v[k][s];
            rfetch = slot_f[k][s];
            rdat   = slot_d[k][s];
            slot_v[k][s] = 1'b0;
            e_ifv = resp & rfetch & ~if_flush;
            e_dv  = resp & ~rfetch;
            e_ifd = e_ifv ? rdat : 32'h0;
            e_dd  = e_dv ? rdat : 32'h0;
            d_ok  = d_req & (~ld_out[k] | e_dv);
            f_ok  = if_req & ~if_flush;
            e_ifg = f_ok & (~d_ok | (starve[k] == SMAX));
            e_dg  = d_ok & ~e_ifg;
            e_stf = if_req & ~e_ifg;
            e_stm = (d_req & ~e_dg) | (ld_out[k] & ~e_dv);
            dw    = d_addr[13:2];
            if (e_dg) begin
                e_we = d_we; e_addr = dw; e_wd = d_wdata;
            end else if (e_ifg) begin
                e_addr = if_addr[13:2];
            end
            if (if_flush) begin
                for (int j = 0; j < 8; j++) if (slot_f[k][j]) slot_v[k][j] = 1'b0;
            end
            t = (cyc + L) % 8;
            if (e_ifg) begin
                slot_v[k][t] = 1'b1; slot_f[k][t] = 1'b1; slot_d[k][t] = ref_mem[k][if_addr[13:2]];
            end
            if (e_dg && d_we == 4'h0) begin
                slot_v[k][t] = 1'b1; slot_f[k][t] = 1'b0; slot_d[k][t] = ref_mem[k][dw];
                ld_out[k] = 1'b1;
            end else if (e_dv) begin
                ld_out[k] = 1'b0;
            end
            if (e_dg && d_we != 4'h0) begin
                for (int b = 0; b < 4; b++) if (d_we[b]) ref_mem[k][dw][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (!if_req || if_flush || e_ifg) starve[k] = 0;
            else if (starve[k] < SMAX) starve[k] = starve[k] + 1;
        end
        ev = {e_ifg, e_dg, e_ifv, e_dv, e_ifg | e_dg, e_stf, e_stm, e_we, e_addr, e_wd, e_ifd, e_dd};
        ov = {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], ram_en[k], stall_F[k], stall_M[k],
              ram_we[k], (e_ifg | e_dg) ? ram_addr[k] : 12'h0, e_dg ? ram_wdata[k] : 32'h0,
              if_rdata[k], d_rdata[k]};
        total++;
        assert (ov === ev) else begin
            bad++;
            $error("FAIL model_lat%0d cyc=%0d observed=%h expected=%h", L, cyc, ov, ev);
        end
    endtask

    task automatic settle();
        #4;
        model_cycle(0);
        model_cycle(1);
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic idle();
        if_req = 0; if_flush = 0; d_req = 0; d_we = 4'h0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    initial begin
        int nd;
        logic got, rvs;
        total = 0; bad = 0; cyc = 0;
        mem_init = 1; rst = 1;
        idle();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4096; i++) ref_mem[k][i] = init_word(12'(i));
            for (int j = 0; j < 8; j++) begin
                slot_v[k][j] = 0; slot_f[k][j] = 0; slot_d[k][j] = 0;
            end
            starve[k] = 0; ld_out[k] = 0;
        end
        adv();
        mem_init = 0;

        // Reset with requests pending: every output low.
        if_req = 1; d_req = 1; if_addr = 32'h100; d_addr = 32'h200;
        settle();
        chk("rst_zero_l1", outs_or(0), 32'h0);
        chk("rst_zero_l2", outs_or(1), 32'h0);
        adv();
        rst = 0; idle();
        repeat (2) step();

        // Lone fetch.
        if_req = 1; if_addr = 32'h100;
        settle();
        chk("t1_if_gnt", 32'(if_gnt[0]), 32'd1);
        chk("t1_ram_addr", 32'(ram_addr[0]), 32'h40);
        adv();
        idle();
        settle();
        chk("t1_if_rvalid", 32'(if_rvalid[0]), 32'd1);
        chk("t1_if_rdata", if_rdata[0], init_word(12'h040));
        adv();
        settle();
        chk("t1_if_rvalid_lat2", 32'(if_rvalid[1]), 32'd1);
        adv();
        step();

        // Simultaneous load and fetch: data first.
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 4'h0; d_addr = 32'h200;
        settle();
        chk("t2_gnts", 32'({d_gnt[0], if_gnt[0], stall_F[0]}), 32'b101);
        adv();
        d_req = 0;
        settle();
        chk("t2_d_rvalid", 32'(d_rvalid[0]), 32'd1);
        chk("t2_d_rdata", d_rdata[0], init_word(12'h080));
        chk("t2_fetch_next", 32'(if_gnt[0]), 32'd1);
        adv();
        idle();
        repeat (3) step();

        // Back-to-back stores against a held fetch.
        got = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                d_req = 1; d_we = 4'hF; d_addr = 32'h400 + 32'(4 * i); d_wdata = $urandom;
                if_req = 1; if_addr = 32'h500;
                settle();
                if (if_gnt[0]) got = 1;
                else if (d_gnt[0]) nd++;
                adv();
            end
        end
        chk("t3_data_grants", 32'(nd), 32'd4);
        chk("t3_fetch_won", 32'(got), 32'd1);
        d_addr = 32'h440; d_wdata = $urandom; if_addr = 32'h504;
        settle();
        chk("t3_starve_clear", 32'({d_gnt[0], if_gnt[0]}), 32'b10);
        adv();
        idle();
        repeat (2) step();

        // Two pipelined fetches killed by a redirect; a load in the window survives.
        if_req = 1; if_addr = 32'h0;
        settle();
        chk("t4_f0_gnt", 32'(if_gnt[1]), 32'd1);
        adv();
        if_addr = 32'h4;
        settle();
        chk("t4_f1_gnt", 32'(if_gnt[1]), 32'd1);
        adv();
        if_flush = 1; if_addr = 32'h80; d_req = 1; d_we = 4'h0; d_addr = 32'h10;
        settle();
        chk("t4_flush_gnts", 32'({if_gnt[1], d_gnt[1]}), 32'b01);
        rvs = if_rvalid[1];
        adv();
        if_flush = 0; d_req = 0;
        settle();
        rvs = rvs | if_rvalid[1];
        adv();
        if_req = 0;
        settle();
        rvs = rvs | if_rvalid[1];
        chk("t4_load_rvalid", 32'(d_rvalid[1]), 32'd1);
        chk("t4_load_rdata", d_rdata[1], init_word(12'h004));
        adv();
        chk("t4_no_stale_fetch", 32'(rvs), 32'd0);
        settle();
        chk("t4_redirect_rdata", if_rdata[1], init_word(12'h020));
        adv();
        repeat (2) step();

        // Partial store followed by a load of the same word.
        d_req = 1; d_we = 4'b0011; d_wdata = 32'hAABBCCDD; d_addr = 32'h8;
        settle();
        chk("t5_ram_we", 32'(ram_we[0]), 32'h3);
        adv();
        d_we = 4'h0;
        settle();
        chk("t5_store_no_rvalid", 32'({d_rvalid[0], d_gnt[0]}), 32'b01);
        adv();
        d_req = 0;
        settle();
        chk("t5_load_lo", 32'(d_rdata[0][15:0]), 32'hCCDD);
        adv();
        repeat (2) step();

        // Reset while a load is in flight.
        d_req = 1; d_we = 4'h0; d_addr = 32'h20;
        step();
        rst = 1; if_req = 1; if_addr = 32'h100; d_addr = 32'h24;
        settle();
        chk("t6_rst_zero_l1", outs_or(0), 32'h0);
        chk("t6_rst_zero_l2", outs_or(1), 32'h0);
        adv();
        rst = 0; idle();
        rvs = 0;
        repeat (3) begin
            settle();
            rvs = rvs | d_rvalid[0] | d_rvalid[1];
            adv();
        end
        chk("t6_no_d_rvalid", 32'(rvs), 32'd0);
        if_req = 1; if_addr = 32'h100;
        settle();
        chk("t6_if_gnt", 32'({if_gnt[0], if_gnt[1]}), 32'b11);
        adv();
        idle();
        settle();
        chk("t6_rv_l1", 32'(if_rvalid[0]), 32'd1);
        adv();
        settle();
        chk("t6_rdata_l2", if_rdata[1], init_word(12'h040));
        adv();

        // Random traffic over a small window of words.
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            if_flush = ($urandom_range(0, 7) == 0);
            if_addr  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2);
            d_req    = ($urandom_range(0, 1) == 1);
            d_we     = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            d_addr   = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2);
            d_wdata  = $urandom;
            step();
        end
        rst = 0; idle();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
